// File: rtl/reset_sequencer.sv
// Reset release sequencer: ADC -> DSP -> UART -> core, then run supervision.
// Restartable; sticky done/failed with a frozen run cycle count.
module reset_sequencer #(
  parameter int unsigned ADC_DLY  = 16,
  parameter int unsigned DSP_DLY  = 8,
  parameter int unsigned UA_DLY   = 8,
  parameter int unsigned CORE_DLY = 8,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned CYC_W    = 64
) (
  input  logic             core_clock,
  input  logic             reset,
  input  logic             restart_req,
  input  logic [CYC_W-1:0] max_cycles,
  input  logic             success,
  output logic             adc_reset,
  output logic             dsp_reset,
  output logic             ua_reset,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic             failed,
  output logic [CYC_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    ASSERT,
    REL_ADC,
    REL_DSP,
    REL_UA,
    RUN,
    DONE,
    FAIL
  } state_e;

  localparam logic [CNT_W-1:0] ADC_LAST  = CNT_W'(ADC_DLY - 1);
  localparam logic [CNT_W-1:0] DSP_LAST  = CNT_W'(DSP_DLY - 1);
  localparam logic [CNT_W-1:0] UA_LAST   = CNT_W'(UA_DLY - 1);
  localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_DLY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             timeout;

  always_ff @(posedge core_clock) begin
    if (!reset) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
    end
  end

  assign timeout = (max_cycles != '0) && (cyc_q >= max_cycles);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    cyc_d   = cyc_q;
    if (restart_req) begin
      state_d = ASSERT;
      cnt_d   = '0;
      cyc_d   = '0;
    end else begin
      unique case (state_q)
        ASSERT: if (cnt_q == ADC_LAST) begin
          state_d = REL_ADC;
          cnt_d   = '0;
        end
        REL_ADC: if (cnt_q == DSP_LAST) begin
          state_d = REL_DSP;
          cnt_d   = '0;
        end
        REL_DSP: if (cnt_q == UA_LAST) begin
          state_d = REL_UA;
          cnt_d   = '0;
        end
        REL_UA: if (cnt_q == CORE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          cyc_d   = '0;
        end
        RUN: begin
          cnt_d = '0;
          // success outranks a simultaneous timeout
          if (success) begin
            state_d = DONE;
          end else if (timeout) begin
            state_d = FAIL;
          end else if (cyc_q != '1) begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        DONE, FAIL: cnt_d = '0;
        default: begin
          state_d = ASSERT;
          cnt_d   = '0;
          cyc_d   = '0;
        end
      endcase
    end
  end

  assign adc_reset   = (state_q == ASSERT);
  assign dsp_reset   = (state_q inside {ASSERT, REL_ADC});
  assign ua_reset    = (state_q inside {ASSERT, REL_ADC, REL_DSP});
  assign core_reset  = (state_q inside {ASSERT, REL_ADC, REL_DSP, REL_UA});
  assign running     = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign failed      = (state_q == FAIL);
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: release timing, run outcomes,
// restart and reset overrides. Stimulus and sampling on the falling edge.
module tb_reset_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        restart;
  logic [63:0] max_c;
  logic        succ;
  logic        adc_r, dsp_r, ua_r, core_r;
  logic        run, dn, fl;
  logic [63:0] cyc;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reset_sequencer dut (
    .core_clock (clk),
    .reset      (rst_n),
    .restart_req(restart),
    .max_cycles (max_c),
    .success    (succ),
    .adc_reset  (adc_r),
    .dsp_reset  (dsp_r),
    .ua_reset   (ua_r),
    .core_reset (core_r),
    .running    (run),
    .done       (dn),
    .failed     (fl),
    .cycle_count(cyc)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_rst(input string tag, input logic [3:0] exp);
    chk(tag, {adc_r, dsp_r, ua_r, core_r}, {60'd0, exp});
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    restart = 1'b0;
    max_c   = '0;
    succ    = 1'b0;
    tick(4);
    chk_rst("rst_resets", 4'b1111);
    chk("rst_run", run, 0);
    chk("rst_done", dn, 0);
    chk("rst_fail", fl, 0);
    chk("rst_cyc", cyc, 0);

    // release order, E0 is the first edge after this point
    rst_n = 1'b1;
    tick(15);
    chk_rst("e0_14", 4'b1111);
    tick(1);
    chk_rst("e0_15", 4'b0111);
    tick(7);
    chk_rst("e0_22", 4'b0111);
    tick(1);
    chk_rst("e0_23", 4'b0011);
    tick(7);
    chk_rst("e0_30", 4'b0011);
    tick(1);
    chk_rst("e0_31", 4'b0001);
    tick(7);
    chk_rst("e0_38", 4'b0001);
    chk("e0_38_run", run, 0);
    tick(1);
    chk_rst("e0_39", 4'b0000);
    chk("e0_39_run", run, 1);
    chk("e0_39_cyc", cyc, 0);
    tick(1);
    chk("run_cyc1", cyc, 1);

    // success on RUN cycle 100
    tick(99);
    chk("succ_pre", cyc, 100);
    succ = 1'b1;
    tick(1);
    succ = 1'b0;
    chk("succ_done", dn, 1);
    chk("succ_run", run, 0);
    chk("succ_cyc", cyc, 100);
    tick(5);
    chk("succ_hold", cyc, 100);
    chk("succ_done2", dn, 1);
    chk_rst("succ_rst", 4'b0000);

    // restart from DONE, then timeout at 50
    do_restart();
    chk_rst("rs_resets", 4'b1111);
    chk("rs_done", dn, 0);
    chk("rs_cyc", cyc, 0);
    tick(15);
    chk_rst("rs_15", 4'b1111);
    tick(1);
    chk_rst("rs_16", 4'b0111);
    tick(24);
    chk_rst("rs_40", 4'b0000);
    chk("rs_run", run, 1);
    max_c = 64'd50;
    tick(50);
    chk("to_cyc50", cyc, 50);
    chk("to_nofail", fl, 0);
    tick(1);
    chk("to_fail", fl, 1);
    chk("to_run", run, 0);
    chk("to_cyc", cyc, 50);
    succ = 1'b1;
    tick(1);
    succ = 1'b0;
    tick(2);
    chk("to_succ_ign", dn, 0);
    chk("to_fail2", fl, 1);
    chk("to_cyc2", cyc, 50);

    // tie: success and timeout together
    do_restart();
    tick(40);
    chk("tie_run", run, 1);
    max_c = 64'd20;
    tick(20);
    chk("tie_cyc", cyc, 20);
    succ = 1'b1;
    tick(1);
    succ = 1'b0;
    chk("tie_done", dn, 1);
    chk("tie_fail", fl, 0);
    chk("tie_cyc2", cyc, 20);

    // mid-sequence restart at E0+20
    max_c = '0;
    do_restart();
    tick(20);
    chk_rst("mr_pre", 4'b0111);
    do_restart();
    chk_rst("mr_all1", 4'b1111);
    tick(15);
    chk_rst("mr_15", 4'b1111);
    tick(1);
    chk_rst("mr_16", 4'b0111);
    tick(23);
    chk_rst("mr_39", 4'b0001);
    tick(1);
    chk_rst("mr_40", 4'b0000);
    chk("mr_run", run, 1);

    // pre-RUN success ignored, then reset in REL_UA
    do_restart();
    tick(5);
    succ = 1'b1;
    tick(1);
    succ = 1'b0;
    chk("pre_done", dn, 0);
    tick(28);
    chk_rst("ua_state", 4'b0001);
    chk("ua_done", dn, 0);
    rst_n = 1'b0;
    tick(1);
    chk_rst("mrst_resets", 4'b1111);
    chk("mrst_run", run, 0);
    chk("mrst_cyc", cyc, 0);
    rst_n = 1'b1;
    tick(40);
    chk("post_run", run, 1);
    chk("post_done", dn, 0);

    // reset overrides restart and success
    rst_n   = 1'b0;
    restart = 1'b1;
    succ    = 1'b1;
    tick(1);
    restart = 1'b0;
    succ    = 1'b0;
    chk_rst("ovr_resets", 4'b1111);
    chk("ovr_done", dn, 0);
    chk("ovr_run", run, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
